// File: rtl/ibex_mem_arbiter.sv
// Fetch/load-store arbiter and address decoder in front of a single-port SRAM and the hwreg block.
// Data wins by default; a fetch denied MAX_INSTR_STALL consecutive cycles is forced through.
// Responses return exactly one cycle after the grant, in order, one outstanding per port.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   instr_req_i/addr_i                fetch request
//   instr_gnt/rvalid/rdata/err_o      fetch grant (same cycle) and response (next cycle)
//   data_req/we/be/addr/wdata_i       load/store request
//   data_gnt/rvalid/rdata/err_o       load/store grant and response
//   sram_*_o, sram_rdata_i            SRAM port, read data valid the cycle after sram_req_o
//   hwreg_*_o, hwreg_rdata_i          hwreg port, read data valid the cycle after hwreg_req_o
//   instr_stall_cnt_o                 saturating count of cycles with a denied fetch
module ibex_mem_arbiter #(
  parameter logic [31:0] MEM_START       = 32'h0000_0000,
  parameter int unsigned MEM_SIZE        = 262144,
  parameter logic [15:0] HWREG_BASE      = 16'hFF00,
  parameter int unsigned MAX_INSTR_STALL = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        sram_req_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_be_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i,
  output logic        hwreg_req_o,
  output logic        hwreg_we_o,
  output logic [15:0] hwreg_addr_o,
  output logic [31:0] hwreg_wdata_o,
  input  logic [31:0] hwreg_rdata_i,
  output logic [15:0] instr_stall_cnt_o
);

  localparam logic [31:0] MemMask  = 32'(MEM_SIZE - 1);
  localparam int unsigned StarveW  = (MAX_INSTR_STALL > 0) ? $clog2(MAX_INSTR_STALL + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_INSTR_STALL);

  typedef enum logic [1:0] {TgtErr, TgtSram, TgtHwreg} tgt_e;

  logic               instr_sram_hit, data_sram_hit, data_hwreg_hit;
  logic               forced;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [15:0]        stall_q, stall_d;
  logic               instr_valid_q, instr_valid_d, data_valid_q, data_valid_d;
  tgt_e               instr_tgt_q, instr_tgt_d, data_tgt_q, data_tgt_d;

  assign instr_sram_hit = (instr_addr_i & ~MemMask) == MEM_START;
  assign data_sram_hit  = (data_addr_i & ~MemMask) == MEM_START;
  assign data_hwreg_hit = data_addr_i[31:16] == HWREG_BASE;

  assign forced      = instr_req_i && (MAX_INSTR_STALL != 0) && (starve_q == StarveMax);
  assign data_gnt_o  = data_req_i && !forced;
  assign instr_gnt_o = instr_req_i && !data_gnt_o;

  always_comb begin
    sram_req_o    = 1'b0;
    sram_we_o     = 1'b0;
    sram_be_o     = 4'h0;
    sram_addr_o   = 32'h0;
    sram_wdata_o  = 32'h0;
    hwreg_req_o   = 1'b0;
    hwreg_we_o    = 1'b0;
    hwreg_addr_o  = 16'h0;
    hwreg_wdata_o = 32'h0;
    if (data_gnt_o) begin
      if (data_sram_hit) begin
        sram_req_o   = 1'b1;
        sram_we_o    = data_we_i;
        sram_be_o    = data_be_i;
        sram_addr_o  = data_addr_i;
        sram_wdata_o = data_wdata_i;
      end else if (data_hwreg_hit) begin
        hwreg_req_o   = 1'b1;
        hwreg_we_o    = data_we_i;
        hwreg_addr_o  = data_addr_i[15:0];
        hwreg_wdata_o = data_wdata_i;
      end
    end else if (instr_gnt_o && instr_sram_hit) begin
      // Fetches from hwreg space are non-executable and fall through to the error response.
      sram_req_o  = 1'b1;
      sram_be_o   = 4'hF;
      sram_addr_o = instr_addr_i;
    end
  end

  always_comb begin
    instr_valid_d = instr_gnt_o;
    data_valid_d  = data_gnt_o;
    instr_tgt_d   = (instr_gnt_o && instr_sram_hit) ? TgtSram : TgtErr;
    data_tgt_d    = TgtErr;
    if (data_gnt_o && data_sram_hit) begin
      data_tgt_d = TgtSram;
    end else if (data_gnt_o && data_hwreg_hit) begin
      data_tgt_d = TgtHwreg;
    end

    starve_d = starve_q;
    if (!instr_req_i || instr_gnt_o) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end

    stall_d = stall_q;
    if (instr_req_i && !instr_gnt_o && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      instr_tgt_q   <= TgtErr;
      data_tgt_q    <= TgtErr;
      starve_q      <= '0;
      stall_q       <= 16'h0;
    end else begin
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
      instr_tgt_q   <= instr_tgt_d;
      data_tgt_q    <= data_tgt_d;
      starve_q      <= starve_d;
      stall_q       <= stall_d;
    end
  end

  // Target is TgtErr whenever no response is pending, so rdata reads 0 when idle.
  always_comb begin
    instr_rdata_o = 32'h0;
    data_rdata_o  = 32'h0;
    unique case (instr_tgt_q)
      TgtSram:  instr_rdata_o = sram_rdata_i;
      TgtHwreg: instr_rdata_o = hwreg_rdata_i;
      default:  instr_rdata_o = 32'h0;
    endcase
    unique case (data_tgt_q)
      TgtSram:  data_rdata_o = sram_rdata_i;
      TgtHwreg: data_rdata_o = hwreg_rdata_i;
      default:  data_rdata_o = 32'h0;
    endcase
  end

  assign instr_rvalid_o    = instr_valid_q;
  assign instr_err_o       = instr_valid_q && (instr_tgt_q == TgtErr);
  assign data_rvalid_o     = data_valid_q;
  assign data_err_o        = data_valid_q && (data_tgt_q == TgtErr);
  assign instr_stall_cnt_o = stall_q;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
module tb_ibex_mem_arbiter;

  localparam int MaxStall = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        sram_req_o, sram_we_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_addr_o, sram_wdata_o, sram_rdata_i;
  logic        hwreg_req_o, hwreg_we_o;
  logic [15:0] hwreg_addr_o;
  logic [31:0] hwreg_wdata_o, hwreg_rdata_i;
  logic [15:0] instr_stall_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ibex_mem_arbiter #(
    .MEM_START      (32'h0000_0000),
    .MEM_SIZE       (262144),
    .HWREG_BASE     (16'hFF00),
    .MAX_INSTR_STALL(MaxStall)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .instr_req_i      (instr_req_i),
    .instr_addr_i     (instr_addr_i),
    .instr_gnt_o      (instr_gnt_o),
    .instr_rvalid_o   (instr_rvalid_o),
    .instr_rdata_o    (instr_rdata_o),
    .instr_err_o      (instr_err_o),
    .data_req_i       (data_req_i),
    .data_we_i        (data_we_i),
    .data_be_i        (data_be_i),
    .data_addr_i      (data_addr_i),
    .data_wdata_i     (data_wdata_i),
    .data_gnt_o       (data_gnt_o),
    .data_rvalid_o    (data_rvalid_o),
    .data_rdata_o     (data_rdata_o),
    .data_err_o       (data_err_o),
    .sram_req_o       (sram_req_o),
    .sram_we_o        (sram_we_o),
    .sram_be_o        (sram_be_o),
    .sram_addr_o      (sram_addr_o),
    .sram_wdata_o     (sram_wdata_o),
    .sram_rdata_i     (sram_rdata_i),
    .hwreg_req_o      (hwreg_req_o),
    .hwreg_we_o       (hwreg_we_o),
    .hwreg_addr_o     (hwreg_addr_o),
    .hwreg_wdata_o    (hwreg_wdata_o),
    .hwreg_rdata_i    (hwreg_rdata_i),
    .instr_stall_cnt_o(instr_stall_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                       input logic [31:0] dwdata);
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = daddr;
    data_wdata_i = dwdata;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Cycle step: inputs change 1 time unit after the rising edge, outputs sampled 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_ni = 1'b0;
    idle();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Region by address range: 0 unmapped, 1 SRAM, 2 hwreg.
  function automatic int region(input logic [31:0] a);
    if (a < 32'h0004_0000) return 1;
    if (a >= 32'hFF00_0000 && a <= 32'hFF00_FFFF) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 2);
    if (r == 0) return $urandom & 32'h0003_FFFC;
    if (r == 1) return 32'hFF00_0000 | ($urandom & 32'h0000_FFFC);
    return 32'h0004_0000 | $urandom;
  endfunction

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic        e_ig, e_dg, e_sram, e_swe, e_hw, e_hwe, e_ierr, e_derr;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int pi, pd, denied_run, stall, ireg, dreg;
    logic forced, e_ig, e_dg, e_sreq, e_hreq;

    rst_ni = 1'b0;
    idle();
    sram_rdata_i  = 32'hDEAD_BEEF;
    hwreg_rdata_i = 32'hCAFE_0041;
    #2;
    chk("rst_instr_rvalid", {31'h0, instr_rvalid_o}, 32'h0);
    chk("rst_data_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    chk("rst_instr_rdata", instr_rdata_o, 32'h0);
    chk("rst_data_rdata", data_rdata_o, 32'h0);
    chk("rst_errs", {30'h0, instr_err_o, data_err_o}, 32'h0);
    chk("rst_stall", {16'h0, instr_stall_cnt_o}, 32'h0);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("rst_comb_gnt", {31'h0, instr_gnt_o}, 32'h1);
    chk("rst_comb_sram_req", {31'h0, sram_req_o}, 32'h1);
    idle();
    @(negedge clk);
    rst_ni = 1'b1;

    //          ireq iaddr          dreq we daddr          ig dg sr swe hw hwe ierr derr irdata drdata
    vecs[0] = '{1, 32'h0000_0100, 0, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0};
    vecs[1] = '{0, 32'h0,         1, 1, 32'hFF00_0000, 0, 1, 0, 0, 1, 1, 0, 0, 0, 32'hCAFE_0041};
    vecs[2] = '{0, 32'h0,         1, 0, 32'h8000_0000, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[3] = '{1, 32'hFF00_0004, 0, 0, 32'h0,         1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[4] = '{1, 32'h0000_0200, 1, 0, 32'h0000_0040, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF};
    vecs[5] = '{0, 32'h0,         1, 0, 32'hFF00_0010, 0, 1, 0, 0, 1, 0, 0, 0, 0, 32'hCAFE_0041};
    vecs[6] = '{0, 32'h0,         1, 1, 32'h0003_FFFC, 0, 1, 1, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF};
    vecs[7] = '{0, 32'h0,         1, 0, 32'h0004_0000, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[8] = '{1, 32'h0003_FFFC, 0, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0};

    foreach (vecs[i]) begin
      next_cycle();
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, 4'b0001, vecs[i].daddr,
            32'h41);
      #3;
      chk($sformatf("v%0d_igt", i), {31'h0, instr_gnt_o}, {31'h0, vecs[i].e_ig});
      chk($sformatf("v%0d_dgt", i), {31'h0, data_gnt_o}, {31'h0, vecs[i].e_dg});
      chk($sformatf("v%0d_sram_req", i), {31'h0, sram_req_o}, {31'h0, vecs[i].e_sram});
      chk($sformatf("v%0d_sram_we", i), {31'h0, sram_we_o}, {31'h0, vecs[i].e_swe});
      chk($sformatf("v%0d_hw_req", i), {31'h0, hwreg_req_o}, {31'h0, vecs[i].e_hw});
      chk($sformatf("v%0d_hw_we", i), {31'h0, hwreg_we_o}, {31'h0, vecs[i].e_hwe});
      if (vecs[i].e_hw) chk($sformatf("v%0d_hw_addr", i), {16'h0, hwreg_addr_o},
                            {16'h0, vecs[i].daddr[15:0]});
      if (vecs[i].e_sram) chk($sformatf("v%0d_sram_addr", i), sram_addr_o,
                              vecs[i].e_dg ? vecs[i].daddr : vecs[i].iaddr);
      next_cycle();
      idle();
      #3;
      chk($sformatf("v%0d_irvalid", i), {31'h0, instr_rvalid_o}, {31'h0, vecs[i].e_ig});
      chk($sformatf("v%0d_drvalid", i), {31'h0, data_rvalid_o}, {31'h0, vecs[i].e_dg});
      chk($sformatf("v%0d_ierr", i), {31'h0, instr_err_o}, {31'h0, vecs[i].e_ierr});
      chk($sformatf("v%0d_derr", i), {31'h0, data_err_o}, {31'h0, vecs[i].e_derr});
      chk($sformatf("v%0d_irdata", i), instr_rdata_o, vecs[i].e_irdata);
      chk($sformatf("v%0d_drdata", i), data_rdata_o, vecs[i].e_drdata);
    end

    // Continuous contention: fetch is forced through on every 5th cycle.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
      #3;
      chk($sformatf("starve_c%0d_igt", k), {31'h0, instr_gnt_o}, {31'h0, (k % 5) == 4});
      chk($sformatf("starve_c%0d_dgt", k), {31'h0, data_gnt_o}, {31'h0, (k % 5) != 4});
      if (k == 5) chk("starve_stall_after_first", {16'h0, instr_stall_cnt_o}, 32'd4);
    end
    next_cycle();
    idle();
    #3;
    chk("starve_stall_total", {16'h0, instr_stall_cnt_o}, 32'd8);

    // Reset right after a data grant drops the pending response.
    next_cycle();
    drive(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    #3;
    chk("mid_rst_dgt", {31'h0, data_gnt_o}, 32'h1);
    next_cycle();
    rst_ni = 1'b0;
    idle();
    #3;
    chk("mid_rst_drvalid_low", {31'h0, data_rvalid_o}, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    next_cycle();
    #3;
    chk("mid_rst_drvalid_after", {31'h0, data_rvalid_o}, 32'h0);
    chk("mid_rst_irvalid_after", {31'h0, instr_rvalid_o}, 32'h0);
    chk("mid_rst_stall", {16'h0, instr_stall_cnt_o}, 32'h0);

    // Randomized traffic against the reference model.
    pi = 0;
    pd = 0;
    denied_run = 0;
    stall = 0;
    for (int c = 0; c < 500; c++) begin
      next_cycle();
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
            1'($urandom), 4'($urandom), rand_addr(), $urandom);
      sram_rdata_i  = $urandom;
      hwreg_rdata_i = $urandom;
      #3;
      ireg   = region(instr_addr_i);
      dreg   = region(data_addr_i);
      forced = instr_req_i && (denied_run >= MaxStall) && (MaxStall != 0);
      e_dg   = data_req_i && !forced;
      e_ig   = instr_req_i && !e_dg;
      e_sreq = (e_dg && dreg == 1) || (e_ig && ireg == 1);
      e_hreq = e_dg && dreg == 2;
      chk($sformatf("r%0d_igt", c), {31'h0, instr_gnt_o}, {31'h0, e_ig});
      chk($sformatf("r%0d_dgt", c), {31'h0, data_gnt_o}, {31'h0, e_dg});
      chk($sformatf("r%0d_sram_req", c), {31'h0, sram_req_o}, {31'h0, e_sreq});
      chk($sformatf("r%0d_hw_req", c), {31'h0, hwreg_req_o}, {31'h0, e_hreq});
      if (e_sreq) begin
        chk($sformatf("r%0d_sram_addr", c), sram_addr_o, e_dg ? data_addr_i : instr_addr_i);
        chk($sformatf("r%0d_sram_ctl", c), {27'h0, sram_we_o, sram_be_o},
            e_dg ? {27'h0, data_we_i, data_be_i} : 32'h0F);
        if (e_dg) chk($sformatf("r%0d_sram_wdata", c), sram_wdata_o, data_wdata_i);
      end
      if (e_hreq) begin
        chk($sformatf("r%0d_hw_ctl", c), {15'h0, hwreg_we_o, hwreg_addr_o},
            {15'h0, data_we_i, data_addr_i[15:0]});
        chk($sformatf("r%0d_hw_wdata", c), hwreg_wdata_o, data_wdata_i);
      end
      chk($sformatf("r%0d_irsp", c), {30'h0, instr_rvalid_o, instr_err_o},
          {30'h0, pi != 0, pi == 3});
      chk($sformatf("r%0d_drsp", c), {30'h0, data_rvalid_o, data_err_o},
          {30'h0, pd != 0, pd == 3});
      chk($sformatf("r%0d_irdata", c), instr_rdata_o,
          (pi == 1) ? sram_rdata_i : (pi == 2) ? hwreg_rdata_i : 32'h0);
      chk($sformatf("r%0d_drdata", c), data_rdata_o,
          (pd == 1) ? sram_rdata_i : (pd == 2) ? hwreg_rdata_i : 32'h0);
      chk($sformatf("r%0d_stall", c), {16'h0, instr_stall_cnt_o}, stall);
      pi = e_ig ? ((ireg == 1) ? 1 : 3) : 0;
      pd = e_dg ? ((dreg == 1) ? 1 : (dreg == 2) ? 2 : 3) : 0;
      if (instr_req_i && !e_ig) begin
        denied_run = (denied_run < MaxStall) ? denied_run + 1 : MaxStall;
        if (stall < 65535) stall++;
      end else begin
        denied_run = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
